// File: rtl/wait_event_pkg.sv
// Shared types and codes for the multi-channel wait-event engine:
// FSM states, condition mode codes and completion status codes.
package wait_event_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_EQ   = 2'b10;
    localparam logic [1:0] MODE_CHG  = 2'b11;

    localparam logic [1:0] ST_ABORT   = 2'b00;
    localparam logic [1:0] ST_HIT     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_SEL_ERR = 2'b11;

endpackage

// File: rtl/wait_cond_detect.sv
// Purely combinational condition detector: compares the current channel
// sample against the previous one (or a match value) according to mode.
module wait_cond_detect
    import wait_event_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] match_val,
    input  logic [1:0]       mode,
    output logic             hit
);

    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_RISE: hit = ~prev[0] &  cur[0];
            MODE_FALL: hit =  prev[0] & ~cur[0];
            MODE_EQ:   hit = (cur == match_val);
            MODE_CHG:  hit = (cur != prev);
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_wait_event.sv
// Waits for an edge/value/change condition on one of CH_NB channels, with an
// optional cycle timeout and abort; reports status and WAIT cycles consumed.
module multi_wait_event
    import wait_event_pkg::*;
#(
    parameter int CH_NB = 5,
    parameter int WIDTH = 32,
    parameter int CNT_W = 32,
    localparam int SEL_W = (CH_NB > 1) ? $clog2(CH_NB) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SEL_W-1:0]       sel,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       match_val,
    input  logic [CNT_W-1:0]       timeout,
    input  logic                   abort,
    input  logic [CH_NB*WIDTH-1:0] signals,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             status,
    output logic [CNT_W-1:0]       elapsed
);

    localparam int IDX_W = (CH_NB * WIDTH > 1) ? $clog2(CH_NB * WIDTH) : 1;

    state_t           state_reg;
    state_t           state_next;
    logic [SEL_W-1:0] sel_reg;
    logic [1:0]       mode_reg;
    logic [WIDTH-1:0] match_reg;
    logic [CNT_W-1:0] timeout_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       status_reg;
    logic [CNT_W-1:0] elapsed_reg;

    logic             sel_in_err;
    logic             sel_reg_ok;
    logic [IDX_W-1:0] base;
    logic [WIDTH-1:0] cur;
    logic             hit;
    logic             to_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign sel_in_err = !(32'(sel) < 32'(CH_NB));
    assign sel_reg_ok = (32'(sel_reg) < 32'(CH_NB));

    // Out-of-range selections only exist in DONE, but keep the read in bounds anyway.
    assign base = sel_reg_ok ? IDX_W'(sel_reg) * IDX_W'(WIDTH) : '0;
    assign cur  = signals[base +: WIDTH];

    // With no timeout the counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign to_hit  = (timeout_reg != '0) && ((cnt_reg + CNT_W'(1)) == timeout_reg);

    wait_cond_detect #(
        .WIDTH(WIDTH)
    ) u_cond (
        .cur      (cur),
        .prev     (prev_reg),
        .match_val(match_reg),
        .mode     (mode_reg),
        .hit      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = sel_in_err ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                state_next = abort ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (abort || hit || to_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_reg == S_ARM) || (state_reg == S_WAIT);
        done = (state_reg == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg     <= '0;
            mode_reg    <= '0;
            match_reg   <= '0;
            timeout_reg <= '0;
            prev_reg    <= '0;
            cnt_reg     <= '0;
            status_reg  <= '0;
            elapsed_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        sel_reg     <= sel;
                        mode_reg    <= mode;
                        match_reg   <= match_val;
                        timeout_reg <= timeout;
                        cnt_reg     <= '0;
                        elapsed_reg <= '0;
                        status_reg  <= sel_in_err ? ST_SEL_ERR : ST_ABORT;
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        status_reg  <= ST_ABORT;
                        elapsed_reg <= cnt_reg;
                    end else begin
                        prev_reg <= cur;
                    end
                end
                S_WAIT: begin
                    // Priority: abort, then hit, then timeout.
                    if (abort) begin
                        status_reg  <= ST_ABORT;
                        elapsed_reg <= cnt_reg;
                    end else if (hit) begin
                        status_reg  <= ST_HIT;
                        elapsed_reg <= cnt_inc;
                    end else if (to_hit) begin
                        status_reg  <= ST_TIMEOUT;
                        elapsed_reg <= timeout_reg;
                    end
                    prev_reg <= cur;
                    cnt_reg  <= cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign status  = status_reg;
    assign elapsed = elapsed_reg;

endmodule

// File: tb/tb_multi_wait_event.sv
// Directed bench for multi_wait_event: cycle numbers count from the cycle in
// which start is high (cycle 0); done_cyc is the first cycle with done=1.
module tb_multi_wait_event;

    localparam int CH_NB = 5;
    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [2:0]             sel;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       match_val;
    logic [CNT_W-1:0]       timeout;
    logic                   abort;
    logic [CH_NB*WIDTH-1:0] signals;
    logic                   busy;
    logic                   done;
    logic [1:0]             status;
    logic [CNT_W-1:0]       elapsed;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int done_cyc;
    int done_cnt;
    logic busy_seen;
    logic overlap;

    multi_wait_event #(
        .CH_NB(CH_NB),
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .mode     (mode),
        .match_val(match_val),
        .timeout  (timeout),
        .abort    (abort),
        .signals  (signals),
        .busy     (busy),
        .done     (done),
        .status   (status),
        .elapsed  (elapsed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (busy) busy_seen = 1'b1;
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic issue(input logic [2:0] s, input logic [1:0] m,
                         input logic [WIDTH-1:0] mv, input logic [CNT_W-1:0] to);
        sel       = s;
        mode      = m;
        match_val = mv;
        timeout   = to;
        start     = 1'b1;
        cyc       = 0;
        done_cyc  = -1;
        done_cnt  = 0;
        busy_seen = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [WIDTH-1:0] v);
        signals[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = '0; mode = '0; match_val = '0;
        timeout = '0; abort = 1'b0; signals = '0; overlap = 1'b0;
        cyc = 0; done_cyc = -1; done_cnt = 0; busy_seen = 1'b0;
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_status", 64'(status), 64'd0);
        chk("reset_elapsed", 64'(elapsed), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Rise on ch2 with bit0 going high during WAIT cycle 4; a start pulse mid-wait is ignored
        set_ch(2, 32'h0000_0010);
        issue(3'd2, 2'b00, 32'h0, 8'd10);
        tick();
        start = 1'b1; sel = 3'd6; mode = 2'b10;
        tick();
        start = 1'b0;
        run_to(5);
        set_ch(2, 32'h0000_0011);
        run_to(8);
        chk("rise_done_cyc", 64'(done_cyc), 64'd6);
        chk("rise_done_cnt", 64'(done_cnt), 64'd1);
        chk("rise_status", 64'(status), 64'd1);
        chk("rise_elapsed", 64'(elapsed), 64'd4);

        // Falling edge that never comes: timeout after 5 WAIT cycles
        set_ch(0, 32'h0);
        issue(3'd0, 2'b01, 32'h0, 8'd5);
        run_to(9);
        chk("to_done_cyc", 64'(done_cyc), 64'd7);
        chk("to_status", 64'(status), 64'd2);
        chk("to_elapsed", 64'(elapsed), 64'd5);

        // Equal value already present: hit on first WAIT cycle
        set_ch(1, 32'hCAFE_DECA);
        issue(3'd1, 2'b10, 32'hCAFE_DECA, 8'd0);
        run_to(5);
        chk("eq_done_cyc", 64'(done_cyc), 64'd3);
        chk("eq_status", 64'(status), 64'd1);
        chk("eq_elapsed", 64'(elapsed), 64'd1);

        // Hit and timeout on the same cycle resolve as a hit
        issue(3'd1, 2'b10, 32'hCAFE_DECA, 8'd1);
        run_to(5);
        chk("eqto_done_cyc", 64'(done_cyc), 64'd3);
        chk("eqto_status", 64'(status), 64'd1);
        chk("eqto_elapsed", 64'(elapsed), 64'd1);

        // Smallest timeout with no hit
        issue(3'd0, 2'b00, 32'h0, 8'd1);
        run_to(5);
        chk("to1_done_cyc", 64'(done_cyc), 64'd3);
        chk("to1_status", 64'(status), 64'd2);
        chk("to1_elapsed", 64'(elapsed), 64'd1);

        // Out-of-range select finishes immediately without ever going busy
        issue(3'd6, 2'b00, 32'h0, 8'd0);
        run_to(4);
        chk("sel_done_cyc", 64'(done_cyc), 64'd1);
        chk("sel_status", 64'(status), 64'd3);
        chk("sel_elapsed", 64'(elapsed), 64'd0);
        chk("sel_busy_seen", 64'(busy_seen), 64'd0);

        // Abort during WAIT cycle 3 beats a simultaneous change on ch4
        set_ch(4, 32'h1234_5678);
        issue(3'd4, 2'b11, 32'h0, 8'd0);
        run_to(4);
        abort = 1'b1;
        set_ch(4, 32'h8765_4321);
        tick();
        abort = 1'b0;
        run_to(7);
        chk("abort_done_cyc", 64'(done_cyc), 64'd5);
        chk("abort_status", 64'(status), 64'd0);
        chk("abort_elapsed", 64'(elapsed), 64'd2);

        // Abort is ignored in IDLE: no activity follows
        abort = 1'b1;
        cyc = 0; done_cyc = -1; done_cnt = 0; busy_seen = 1'b0;
        run_to(3);
        abort = 1'b0;
        chk("idle_abort_busy", 64'(busy_seen), 64'd0);
        chk("idle_abort_done", 64'(done_cnt), 64'd0);

        // Reset in WAIT cycle 2 abandons the wait without a done pulse
        set_ch(2, 32'h0000_0007);
        issue(3'd2, 2'b11, 32'h0, 8'd0);
        run_to(3);
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_elapsed", 64'(elapsed), 64'd0);
        run_to(6);
        rst = 1'b0;
        run_to(8);
        chk("rst_no_done", 64'(done_cnt), 64'd0);

        issue(3'd1, 2'b10, 32'hCAFE_DECA, 8'd0);
        run_to(5);
        chk("post_rst_done_cyc", 64'(done_cyc), 64'd3);
        chk("post_rst_status", 64'(status), 64'd1);
        chk("post_rst_elapsed", 64'(elapsed), 64'd1);

        // Unbounded wait: counter saturates at all-ones, then abort reports it
        set_ch(3, 32'h0000_0055);
        issue(3'd3, 2'b11, 32'h0, 8'd0);
        run_to(300);
        chk("sat_still_busy", 64'(busy), 64'd1);
        chk("sat_no_done", 64'(done_cnt), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_to(303);
        chk("sat_done_cnt", 64'(done_cnt), 64'd1);
        chk("sat_status", 64'(status), 64'd0);
        chk("sat_elapsed", 64'(elapsed), 64'd255);

        chk("busy_done_overlap", 64'(overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
